tohost_monitor: RTL
===================

TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 The block SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, the word address whose stores end a test.
REQ-002 The block SHALL have parameter STALL_LIMIT, default 1024, the maximum cycles without a retired instruction before HUNG (range 2..2^16).
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 in_write_enable  input  1  core store strobe, taken from the memWrite enable.
REQ-006 in_write_address  input  32  store address.
REQ-007 in_write_data  input  32  store data.
REQ-008 in_pc  input  32  PC of the retiring instruction.
REQ-009 in_pc_enable  input  1  retire strobe, one per instruction.
REQ-010 out_done  output  1  high when the state is not RUN.
REQ-011 out_pass  output  1  high only in PASS.
REQ-012 out_fail_code  output  31  in FAIL, tohost data[31:1]; otherwise 0.
REQ-013 out_retired  output  32  count of retired instructions.
REQ-014 out_state  output  2  RUN=0, PASS=1, FAIL=2, HUNG=3.
REQ-015 out_last_pc  output  32  PC of the most recent retire.

Function
REQ-016 All outputs SHALL be registered, so a qualifying input is visible on the outputs exactly 1 cycle after the edge that samples it.
REQ-017 A tohost hit SHALL be defined as in_write_enable=1 and in_write_address==TOHOST_ADDR; stores to TOHOST_ADDR+4 and all other addresses SHALL be ignored.
REQ-018 In RUN, a tohost hit with data==32'h1 SHALL move the state to PASS.
REQ-019 In RUN, a tohost hit with data[0]=1 and data!=1 SHALL move the state to FAIL and latch out_fail_code=data[31:1].
REQ-020 In RUN, a tohost hit with data[0]=0 SHALL be ignored; the state stays RUN.
REQ-021 PASS, FAIL and HUNG SHALL be terminal: further hits, retires and stalls SHALL have no effect until RESET.
REQ-022 In RUN, each in_pc_enable SHALL increment out_retired and load out_last_pc.
- out_retired saturates at 32'hFFFF_FFFF; it does not wrap.
REQ-023 In a terminal state, out_retired and out_last_pc SHALL freeze.
REQ-024 When in_pc_enable and a tohost hit occur in the same cycle, the retire SHALL be counted and the state SHALL change on the same edge.
REQ-025 The stall counter SHALL clear on every in_pc_enable and increment on each RUN cycle without one.
- When the counter equals STALL_LIMIT-1 and in_pc_enable=0, the state SHALL move to HUNG.
REQ-026 When stall expiry and a tohost hit occur in the same cycle, the tohost hit SHALL take precedence.

Reset
REQ-027 With RESET=1 at an edge, the block SHALL set state=RUN, out_done=0, out_pass=0, out_fail_code=0, out_retired=0, out_last_pc=0, stall counter=0.
REQ-028 RESET SHALL override every other input in that cycle, including mid-test and from a terminal state.

Configuration
REQ-029 Macro TOHOST_WATCHDOG_EN, when defined, SHALL compile in the stall counter and the HUNG transition.
REQ-030 Without TOHOST_WATCHDOG_EN, the counter logic SHALL be absent, HUNG SHALL be unreachable, and RUN SHALL last until a tohost hit or RESET.

Structure
REQ-031 A shared package SHALL hold the monitor_state_t enum (RUN, PASS, FAIL, HUNG), the default TOHOST_ADDR constant and the PASS code constant 32'h1.
REQ-032 The stall counter SHALL be a sub-module stall_watchdog with ports clear, tick and limit, and output expired; it SHALL only be instantiated under TOHOST_WATCHDOG_EN.

Verification
REQ-033 Retire 5 instructions (PC 0x80000000..0x80000010), then a store of 0x1 to 0x1000 -> next cycle out_pass=1, out_state=1, out_retired=5, out_last_pc=0x80000010.
REQ-034 A store of 0x7 to 0x1000 -> out_state=2, out_fail_code=3, out_pass=0; a later store of 0x1 -> still FAIL.
REQ-035 A store of 0x1 to 0x1004, then a store of 0x2 to 0x1000 -> out_state stays 0 for both.
REQ-036 With TOHOST_WATCHDOG_EN and STALL_LIMIT=8, retire once then idle -> out_state=3 exactly 8 cycles after the retire edge; with a store of 0x1 to 0x1000 on the expiry cycle -> PASS instead.
REQ-037 Preload out_retired to 32'hFFFF_FFFE via stimulus, retire 3 more -> out_retired=32'hFFFF_FFFF.
REQ-038 Assert RESET for one cycle while in PASS with out_retired=40 -> next cycle all outputs are 0 and out_state=0; the next store of 0x1 to 0x1000 -> PASS again.

Source files
------------

// File: rtl/tohost_monitor_pkg.sv
// ----------------------------------------------------------------------------
// tohost_monitor_pkg
// Shared definitions for the tohost test-completion monitor.
//   monitor_state_t     : RUN / PASS / FAIL / HUNG, encoded to match out_state
//   DEFAULT_TOHOST_ADDR : word address whose stores end a test
//   PASS_CODE           : tohost value that signals a passing test
//   STALL_CNT_W         : width of the stall counter; holds any STALL_LIMIT
//                         in 2..2^16
//   sat_inc32()         : 32-bit increment that sticks at all-ones
// ----------------------------------------------------------------------------
package tohost_monitor_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        HUNG = 2'd3
    } monitor_state_t;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
    localparam logic [31:0] PASS_CODE           = 32'h0000_0001;
    localparam int          STALL_CNT_W         = 17;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/tohost_monitor_stall_watchdog.sv
// ----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive cycles without a retired instruction. 'expired' is high
// during the cycle in which the next tick would reach 'limit', so the owner
// can act on the same edge that would have made the count equal 'limit'.
// Only compiled into the monitor when TOHOST_WATCHDOG_EN is defined.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high
//   clear   in   restart the count (an instruction retired)
//   tick    in   one idle cycle has elapsed
//   limit   in   number of idle cycles that counts as a hang
//   expired out  the current tick is the limit-th idle cycle
// ----------------------------------------------------------------------------
module stall_watchdog
    import tohost_monitor_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   tick,
    input  logic [STALL_CNT_W-1:0] limit,
    output logic                   expired
);

    localparam logic [STALL_CNT_W-1:0] ONE = STALL_CNT_W'(1);

    logic [STALL_CNT_W-1:0] count;

    // A retire in the same cycle wins over the idle tick.
    assign expired = tick && !clear && (count == (limit - ONE));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// ----------------------------------------------------------------------------
// tohost_monitor
// Watches the core's store port for writes to the tohost word and reports the
// test outcome. A store to TOHOST_ADDR with value 1 means PASS, any other odd
// value means FAIL with code data[31:1], even values are ignored. Also counts
// retired instructions and remembers the last retired PC. PASS, FAIL and HUNG
// are terminal until RESET.
//
// Optional feature: define TOHOST_WATCHDOG_EN to build in the stall watchdog,
// which moves the monitor to HUNG after STALL_LIMIT consecutive RUN cycles
// without a retire. Without it HUNG is unreachable.
//
// Parameters
//   TOHOST_ADDR  word address whose stores end a test
//   STALL_LIMIT  idle cycles before HUNG (2..2^16), watchdog build only
//
// Ports
//   CLK               in   clock, rising edge
//   RESET             in   synchronous, active-high, overrides everything
//   in_write_enable   in   store strobe
//   in_write_address  in   store address
//   in_write_data     in   store data
//   in_pc             in   PC of the retiring instruction
//   in_pc_enable      in   retire strobe
//   out_done          out  state is not RUN
//   out_pass          out  state is PASS
//   out_fail_code     out  tohost data[31:1] in FAIL, else 0
//   out_retired       out  saturating count of retired instructions
//   out_state         out  RUN=0 PASS=1 FAIL=2 HUNG=3
//   out_last_pc       out  PC of the most recent retire
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_write_enable,
    input  logic [31:0] in_write_address,
    input  logic [31:0] in_write_data,
    input  logic [31:0] in_pc,
    input  logic        in_pc_enable,
    output logic        out_done,
    output logic        out_pass,
    output logic [30:0] out_fail_code,
    output logic [31:0] out_retired,
    output logic [1:0]  out_state,
    output logic [31:0] out_last_pc
);

    if (STALL_LIMIT < 2 || STALL_LIMIT > 65536) begin : g_bad_stall_limit
        $error("tohost_monitor: STALL_LIMIT must lie in 2..65536");
    end

    monitor_state_t state;
    logic           pass_hit;
    logic           fail_hit;
    logic           stall_expired;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pass_hit = 1'b0;
        fail_hit = 1'b0;
        if (in_write_enable && (in_write_address == TOHOST_ADDR) && in_write_data[0]) begin
            pass_hit = (in_write_data == PASS_CODE);
            fail_hit = (in_write_data != PASS_CODE);
        end
    end

`ifdef TOHOST_WATCHDOG_EN
    // Ticks only while running; terminal states freeze the count.
    stall_watchdog u_stall_watchdog (
        .clk     (CLK),
        .reset   (RESET),
        .clear   (in_pc_enable),
        .tick    ((state == RUN) && !in_pc_enable),
        .limit   (STALL_CNT_W'(STALL_LIMIT)),
        .expired (stall_expired)
    );
`else
    assign stall_expired = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= RUN;
            out_done      <= 1'b0;
            out_pass      <= 1'b0;
            out_fail_code <= '0;
            out_retired   <= '0;
            out_last_pc   <= '0;
        end else if (state == RUN) begin
            // A retire alongside a terminating store is still counted.
            if (in_pc_enable) begin
                out_retired <= sat_inc32(out_retired);
                out_last_pc <= in_pc;
            end
            // A tohost result outranks a watchdog expiry on the same edge.
            if (pass_hit) begin
                state    <= PASS;
                out_done <= 1'b1;
                out_pass <= 1'b1;
            end else if (fail_hit) begin
                state         <= FAIL;
                out_done      <= 1'b1;
                out_fail_code <= in_write_data[31:1];
            end else if (stall_expired) begin
                state    <= HUNG;
                out_done <= 1'b1;
            end
        end
    end

    assign out_state = state;

endmodule
